// File: rtl/issue_stage_n_pkg.sv
// Shared constants for the issue stage: class codes, the "value ready" tag,
// opcodes agreed with the decoder, and the immediate extension helper.
package issue_stage_n_pkg;

    localparam int TAG_NONE = 0;

    localparam int CLS_ALU = 0;
    localparam int CLS_MEM = 1;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00,
        OP_SUB  = 6'h01,
        OP_AND  = 6'h02,
        OP_OR   = 6'h03,
        OP_ADDI = 6'h08,
        OP_LW   = 6'h23,
        OP_SW   = 6'h2B
    } opcode_e;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zext);
        return {{16{~zext & imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/issue_stage_n_if.sv
// Decoder-to-issue handshake bundle.
// A transfer happens on a rising clk edge where in_valid & in_ready are both 1;
// the fields must be stable while in_valid is high, and in_ready may depend on in_valid.
interface issue_stage_n_if #(
    parameter int CLS_W = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_op;
    logic [CLS_W-1:0] in_cls;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [4:0]       in_rd;
    logic [15:0]      in_imm16;
    logic             in_imm_zext;

    modport master (
        output in_valid, in_op, in_cls, in_rs, in_rt, in_rd, in_imm16, in_imm_zext,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_cls, in_rs, in_rt, in_rd, in_imm16, in_imm_zext,
        output in_ready
    );
endinterface

// File: rtl/issue_stage_n_operand_capture.sv
// One source operand: accept-time tag/value selection, then CDB snooping
// while the instruction waits, with the current broadcast applied on the output.
module issue_stage_n_operand_capture
    import issue_stage_n_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              held,
    input  logic              fwd_hit,
    input  logic [TAG_W-1:0]  fwd_tag,
    input  logic [TAG_W-1:0]  label,
    input  logic [DATA_W-1:0] data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] val
);
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] val_q;
    logic              label_hit;
    logic              held_hit;

    assign label_hit = (label != TAG_W'(TAG_NONE)) && cdb_valid && (cdb_tag == label);
    assign held_hit  = (tag_q != TAG_W'(TAG_NONE)) && cdb_valid && (cdb_tag == tag_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
            val_q <= '0;
        end else if (accept) begin
            // The instruction leaving this cycle renames the register we read,
            // so the status table is stale: wait on its new tag instead.
            if (fwd_hit) begin
                tag_q <= fwd_tag;
                val_q <= '0;
            end else if (label_hit) begin
                tag_q <= '0;
                val_q <= cdb_data;
            end else begin
                tag_q <= label;
                val_q <= data;
            end
        end else if (held && held_hit) begin
            tag_q <= '0;
            val_q <= cdb_data;
        end
    end

    assign tag = (!held || held_hit) ? '0 : tag_q;
    assign val = !held ? '0 : (held_hit ? cdb_data : val_q);

endmodule

// File: rtl/issue_stage_n.sv
// One-entry issue stage between the decoder and the reservation-station classes:
// holds a decoded instruction until its class offers a tag, then dispatches and renames rd.
module issue_stage_n
    import issue_stage_n_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int NUM_CLS = 2,
    parameter int CLS_W   = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    issue_stage_n_if.slave           dec,
    output logic [4:0]               readAddr1,
    output logic [4:0]               readAddr2,
    input  logic [TAG_W-1:0]         labelIn1,
    input  logic [TAG_W-1:0]         labelIn2,
    input  logic [DATA_W-1:0]        dataIn1,
    input  logic [DATA_W-1:0]        dataIn2,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [DATA_W-1:0]        cdb_data,
    input  logic [NUM_CLS-1:0]       free_valid,
    input  logic [NUM_CLS*TAG_W-1:0] free_tag,
    output logic [NUM_CLS-1:0]       iss_valid,
    output logic [5:0]               iss_op,
    output logic [TAG_W-1:0]         iss_tag1,
    output logic [TAG_W-1:0]         iss_tag2,
    output logic [DATA_W-1:0]        iss_val1,
    output logic [DATA_W-1:0]        iss_val2,
    output logic [31:0]              iss_imm,
    output logic [TAG_W-1:0]         iss_dest,
    output logic                     rat_we,
    output logic [4:0]               rat_addr,
    output logic [TAG_W-1:0]         rat_tag,
    output logic [CNT_W-1:0]         stall_cnt
);
    // Every encodable class code gets a table slot; codes past NUM_CLS read as never free.
    localparam int CLS_SPAN = 1 << CLS_W;
    localparam logic [CLS_SPAN-1:0] LEGAL_CLS = CLS_SPAN'((1 << NUM_CLS) - 1);

    logic             held_v;
    logic [5:0]       op_q;
    logic [CLS_W-1:0] cls_q;
    logic [4:0]       rd_q;
    logic [31:0]      imm_q;
    logic [CNT_W-1:0] stall_q;

    logic [CLS_SPAN-1:0] free_ext;
    logic [TAG_W-1:0]    tag_tbl [CLS_SPAN];
    logic [TAG_W-1:0]    sel_tag;
    logic                free_ok;
    logic                fire;
    logic                ready;
    logic                accept;
    logic                fwd1;
    logic                fwd2;

    always_comb begin
        free_ext = '0;
        for (int c = 0; c < CLS_SPAN; c++) tag_tbl[c] = '0;
        for (int c = 0; c < NUM_CLS; c++) begin
            free_ext[c] = free_valid[c];
            tag_tbl[c]  = free_tag[c*TAG_W +: TAG_W];
        end
    end

    assign free_ok = free_ext[cls_q];
    assign sel_tag = tag_tbl[cls_q];
    assign fire    = held_v & free_ok & ~flush;
    assign ready   = ~flush & (~held_v | fire);
    assign accept  = dec.in_valid & ready;
    assign fwd1    = fire && (rd_q != 5'd0) && (rd_q == dec.in_rs);
    assign fwd2    = fire && (rd_q != 5'd0) && (rd_q == dec.in_rt);

    assign dec.in_ready = ready;
    assign readAddr1    = dec.in_rs;
    assign readAddr2    = dec.in_rt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_v  <= 1'b0;
            op_q    <= '0;
            cls_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            stall_q <= '0;
        end else begin
            if (accept) begin
                held_v <= 1'b1;
                op_q   <= dec.in_op;
                cls_q  <= dec.in_cls;
                rd_q   <= dec.in_rd;
                imm_q  <= ext_imm(dec.in_imm16, dec.in_imm_zext);
            end else if (fire || flush) begin
                held_v <= 1'b0;
            end
            if (held_v && !fire && !flush && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    issue_stage_n_operand_capture #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src1 (
        .clk(clk), .rst(rst), .accept(accept), .held(held_v),
        .fwd_hit(fwd1), .fwd_tag(sel_tag), .label(labelIn1), .data(dataIn1),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .tag(iss_tag1), .val(iss_val1)
    );

    issue_stage_n_operand_capture #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_src2 (
        .clk(clk), .rst(rst), .accept(accept), .held(held_v),
        .fwd_hit(fwd2), .fwd_tag(sel_tag), .label(labelIn2), .data(dataIn2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .tag(iss_tag2), .val(iss_val2)
    );

    always_comb begin
        iss_valid = '0;
        for (int c = 0; c < NUM_CLS; c++)
            iss_valid[c] = fire && (cls_q == CLS_W'(c));
    end

    assign iss_op    = held_v ? op_q : '0;
    assign iss_imm   = held_v ? imm_q : '0;
    assign iss_dest  = fire ? sel_tag : '0;
    assign rat_we    = fire && (rd_q != 5'd0);
    assign rat_addr  = held_v ? rd_q : '0;
    assign rat_tag   = fire ? sel_tag : '0;
    assign stall_cnt = stall_q;

    a_onehot_issue: assert property (@(posedge clk) disable iff (rst) $onehot0(iss_valid));
    a_legal_issue:  assert property (@(posedge clk) disable iff (rst) fire |-> LEGAL_CLS[cls_q]);
    c_illegal_cls:  cover property (@(posedge clk) disable iff (rst) accept && !LEGAL_CLS[dec.in_cls]);

endmodule

// File: tb/tb_issue_stage_n.sv
// Bench for issue_stage_n: directed scenarios plus random traffic, all checked
// against a transaction-level model of the held instruction and an issue scoreboard.
module tb_issue_stage_n;
    localparam int DW   = 32;
    localparam int TW   = 5;
    localparam int NC   = 3;
    localparam int CW   = 2;
    localparam int CNTW = 4;
    localparam int SMAX = (1 << CNTW) - 1;
    localparam int PW   = 6 + TW + DW + TW + DW + 32 + TW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_stage_n_if #(.CLS_W(CW)) dec_bus ();

    logic              flush;
    logic [4:0]        readAddr1, readAddr2;
    logic [TW-1:0]     label1, label2;
    logic [DW-1:0]     data1, data2;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [NC-1:0]     free_valid;
    logic [NC*TW-1:0]  free_tag;
    logic [NC-1:0]     iss_valid;
    logic [5:0]        iss_op;
    logic [TW-1:0]     iss_tag1, iss_tag2, iss_dest, rat_tag;
    logic [DW-1:0]     iss_val1, iss_val2;
    logic [31:0]       iss_imm;
    logic              rat_we;
    logic [4:0]        rat_addr;
    logic [CNTW-1:0]   stall_cnt;

    issue_stage_n #(.DATA_W(DW), .TAG_W(TW), .NUM_CLS(NC), .CLS_W(CW), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dec(dec_bus),
        .readAddr1(readAddr1), .readAddr2(readAddr2),
        .labelIn1(label1), .labelIn2(label2), .dataIn1(data1), .dataIn2(data2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .free_valid(free_valid), .free_tag(free_tag),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_tag1(iss_tag1), .iss_tag2(iss_tag2),
        .iss_val1(iss_val1), .iss_val2(iss_val2), .iss_imm(iss_imm), .iss_dest(iss_dest),
        .rat_we(rat_we), .rat_addr(rat_addr), .rat_tag(rat_tag), .stall_cnt(stall_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic        v;
        logic [5:0]  op;
        int          cls;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [TW-1:0] t1, t2;
        logic [DW-1:0] v1, v2;
    } rec_t;

    rec_t h;
    int   stall_m;
    logic [PW-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] tag_of(input int c);
        return free_tag[c*TW +: TW];
    endfunction

    function automatic void capture(input logic [4:0] src, input logic [TW-1:0] lab,
                                    input logic [DW-1:0] dat, input logic fw,
                                    input logic [4:0] hrd, input logic [TW-1:0] dtag,
                                    output logic [TW-1:0] t, output logic [DW-1:0] v);
        if (fw && hrd != 0 && hrd == src) begin
            t = dtag; v = '0;
        end else if (lab != 0 && cdb_valid && cdb_tag == lab) begin
            t = '0; v = cdb_data;
        end else begin
            t = lab; v = dat;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        dec_bus.in_valid = 1'b0; dec_bus.in_op = '0; dec_bus.in_cls = '0;
        dec_bus.in_rs = '0; dec_bus.in_rt = '0; dec_bus.in_rd = '0;
        dec_bus.in_imm16 = '0; dec_bus.in_imm_zext = 1'b0;
        flush = 1'b0; label1 = '0; label2 = '0; data1 = '0; data2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        free_valid = '0; free_tag = '0;
    endtask

    task automatic drive_in(input logic [5:0] op, input logic [CW-1:0] cls, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [15:0] imm, input logic zext);
        dec_bus.in_valid = 1'b1; dec_bus.in_op = op; dec_bus.in_cls = cls;
        dec_bus.in_rs = rs; dec_bus.in_rt = rt; dec_bus.in_rd = rd;
        dec_bus.in_imm16 = imm; dec_bus.in_imm_zext = zext;
    endtask

    task automatic set_free(input logic [NC-1:0] v, input logic [TW-1:0] t0,
                            input logic [TW-1:0] t1, input logic [TW-1:0] t2);
        free_valid = v;
        free_tag   = {t2, t1, t0};
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        h = '{default: 0};
        stall_m = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Compare every output with the model, feed the scoreboard, advance the model one cycle.
    task automatic commit();
        logic ok, fire_m, rdy, acc;
        logic [TW-1:0] d, et1, et2;
        logic [DW-1:0] ev1, ev2;
        logic [NC-1:0] ev;
        rec_t nh;
        ok = 1'b0;
        if (h.v && h.cls < NC) ok = free_valid[h.cls];
        fire_m = ok && !flush;
        rdy    = !flush && (!h.v || fire_m);
        d      = fire_m ? tag_of(h.cls) : '0;
        et1 = h.t1; ev1 = h.v1; et2 = h.t2; ev2 = h.v2;
        if (h.t1 != 0 && cdb_valid && cdb_tag == h.t1) begin et1 = '0; ev1 = cdb_data; end
        if (h.t2 != 0 && cdb_valid && cdb_tag == h.t2) begin et2 = '0; ev2 = cdb_data; end
        if (!h.v) begin et1 = '0; ev1 = '0; et2 = '0; ev2 = '0; end
        ev = fire_m ? NC'(1 << h.cls) : '0;

        check("in_ready",  128'(dec_bus.in_ready), 128'(rdy));
        check("readAddr1", 128'(readAddr1), 128'(dec_bus.in_rs));
        check("readAddr2", 128'(readAddr2), 128'(dec_bus.in_rt));
        check("iss_valid", 128'(iss_valid), 128'(ev));
        check("iss_op",    128'(iss_op), 128'(h.v ? h.op : 6'd0));
        check("iss_tag1",  128'(iss_tag1), 128'(et1));
        check("iss_val1",  128'(iss_val1), 128'(ev1));
        check("iss_tag2",  128'(iss_tag2), 128'(et2));
        check("iss_val2",  128'(iss_val2), 128'(ev2));
        check("iss_imm",   128'(iss_imm), 128'(h.v ? h.imm : 32'd0));
        check("iss_dest",  128'(iss_dest), 128'(d));
        check("rat_we",    128'(rat_we), 128'(fire_m && h.rd != 0));
        check("rat_addr",  128'(rat_addr), 128'(h.v ? h.rd : 5'd0));
        check("rat_tag",   128'(rat_tag), 128'(d));
        check("stall_cnt", 128'(stall_cnt), 128'(stall_m));

        if (fire_m) exp_q.push_back({h.op, et1, ev1, et2, ev2, h.imm, d});
        if (iss_valid != 0) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_issue", 128'(iss_valid), 128'(0));
            else
                check("sb_packet", 128'({iss_op, iss_tag1, iss_val1, iss_tag2, iss_val2, iss_imm, iss_dest}),
                      128'(exp_q.pop_front()));
        end

        acc = dec_bus.in_valid && rdy;
        nh  = h;
        if (rst) begin
            nh = '{default: 0};
        end else if (acc) begin
            nh.v   = 1'b1;
            nh.op  = dec_bus.in_op;
            nh.cls = int'(dec_bus.in_cls);
            nh.rd  = dec_bus.in_rd;
            nh.imm = dec_bus.in_imm_zext ? {16'h0, dec_bus.in_imm16} : 32'($signed(dec_bus.in_imm16));
            capture(dec_bus.in_rs, label1, data1, fire_m, h.rd, d, nh.t1, nh.v1);
            capture(dec_bus.in_rt, label2, data2, fire_m, h.rd, d, nh.t2, nh.v2);
        end else if (fire_m || flush) begin
            nh.v = 1'b0;
        end else if (h.v) begin
            nh.t1 = et1; nh.v1 = ev1; nh.t2 = et2; nh.v2 = ev2;
        end
        if (rst) stall_m = 0;
        else if (h.v && !fire_m && !flush && stall_m < SMAX) stall_m++;
        @(posedge clk);
        h = nh;
        #1;
    endtask

    task automatic step();
        settle();
        commit();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        assert_reset();
        repeat (2) step();
        rst = 1'b0;
        step();

        // Reset in the middle of a hold
        drive_in(6'h00, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        step();
        idle();
        step();
        assert_reset();
        settle();
        check("rst_iss_valid", 128'(iss_valid), 128'(0));
        check("rst_in_ready",  128'(dec_bus.in_ready), 128'(1));
        check("rst_stall",     128'(stall_cnt), 128'(0));
        commit();
        rst = 1'b0;
        step();

        // Plain add, operand 1 ready in the register file
        drive_in(6'h00, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        data1 = 32'd7;
        step();
        idle();
        set_free(3'b001, 5'd3, 5'd0, 5'd0);
        settle();
        check("add_iss_valid", 128'(iss_valid), 128'(3'b001));
        check("add_val1",      128'(iss_val1), 128'(7));
        check("add_dest",      128'(iss_dest), 128'(3));
        check("add_rat_we",    128'(rat_we), 128'(1));
        check("add_rat_tag",   128'(rat_tag), 128'(3));
        commit();
        idle();

        // Operand waits on tag 4, broadcast arrives while stalled
        drive_in(6'h01, 2'd0, 5'd1, 5'd2, 5'd9, 16'h0, 1'b0);
        label1 = 5'd4;
        step();
        idle();
        step();
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'h55;
        step();
        idle();
        step();
        set_free(3'b001, 5'd7, 5'd0, 5'd0);
        settle();
        check("snoop_tag1",  128'(iss_tag1), 128'(0));
        check("snoop_val1",  128'(iss_val1), 128'(32'h55));
        check("snoop_stall", 128'(stall_cnt), 128'(3));
        commit();
        idle();

        // Back-to-back: consumer of r5 arrives as producer of r5 issues
        drive_in(6'h00, 2'd0, 5'd1, 5'd2, 5'd5, 16'h0, 1'b0);
        step();
        drive_in(6'h00, 2'd0, 5'd5, 5'd0, 5'd7, 16'h0, 1'b0);
        data1 = 32'h123;
        set_free(3'b001, 5'd6, 5'd0, 5'd0);
        settle();
        check("b2b_in_ready", 128'(dec_bus.in_ready), 128'(1));
        check("b2b_dest",     128'(iss_dest), 128'(6));
        check("b2b_rat_addr", 128'(rat_addr), 128'(5));
        commit();
        idle();
        settle();
        check("b2b_fwd_tag1", 128'(iss_tag1), 128'(6));
        check("b2b_fwd_val1", 128'(iss_val1), 128'(0));
        commit();
        set_free(3'b001, 5'd8, 5'd0, 5'd0);
        step();
        idle();

        // Accept-time CDB hit on operand 2, sign-extended immediate, MEM class
        drive_in(6'h23, 2'd1, 5'd1, 5'd3, 5'd4, 16'h8000, 1'b0);
        label2 = 5'd9;
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'hAA;
        step();
        idle();
        set_free(3'b010, 5'd0, 5'd10, 5'd0);
        settle();
        check("acc_cdb_valid", 128'(iss_valid), 128'(3'b010));
        check("acc_cdb_tag2",  128'(iss_tag2), 128'(0));
        check("acc_cdb_val2",  128'(iss_val2), 128'(32'hAA));
        check("imm_sext",      128'(iss_imm), 128'(32'hFFFF8000));
        commit();
        drive_in(6'h08, 2'd0, 5'd1, 5'd3, 5'd4, 16'h8000, 1'b1);
        step();
        idle();
        set_free(3'b001, 5'd11, 5'd0, 5'd0);
        settle();
        check("imm_zext", 128'(iss_imm), 128'(32'h00008000));
        commit();
        idle();

        // Flush a held instruction that could have issued
        drive_in(6'h00, 2'd0, 5'd1, 5'd2, 5'd4, 16'h0, 1'b0);
        step();
        drive_in(6'h00, 2'd0, 5'd1, 5'd2, 5'd6, 16'h0, 1'b0);
        flush = 1'b1;
        set_free(3'b001, 5'd12, 5'd0, 5'd0);
        settle();
        check("flush_iss_valid", 128'(iss_valid), 128'(0));
        check("flush_rat_we",    128'(rat_we), 128'(0));
        check("flush_in_ready",  128'(dec_bus.in_ready), 128'(0));
        commit();
        idle();
        set_free(3'b001, 5'd12, 5'd0, 5'd0);
        settle();
        check("post_flush_valid", 128'(iss_valid), 128'(0));
        check("post_flush_ready", 128'(dec_bus.in_ready), 128'(1));
        commit();

        // Destination $0 consumes a tag but does not rename
        drive_in(6'h00, 2'd0, 5'd1, 5'd2, 5'd0, 16'h0, 1'b0);
        step();
        idle();
        set_free(3'b001, 5'd13, 5'd0, 5'd0);
        settle();
        check("rd0_iss_valid", 128'(iss_valid), 128'(3'b001));
        check("rd0_rat_we",    128'(rat_we), 128'(0));
        commit();
        idle();

        // Illegal class never issues, even with every class free
        drive_in(6'h00, 2'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        set_free(3'b111, 5'd1, 5'd2, 5'd3);
        step();
        for (int i = 0; i < 3; i++) begin
            dec_bus.in_valid = 1'b0;
            settle();
            check("illegal_no_issue", 128'(iss_valid), 128'(0));
            check("illegal_blocked",  128'(dec_bus.in_ready), 128'(0));
            commit();
        end
        idle();
        flush = 1'b1;
        step();
        idle();

        // Stall counter saturates instead of wrapping
        drive_in(6'h00, 2'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        step();
        idle();
        repeat (SMAX + 5) step();
        settle();
        check("stall_saturate", 128'(stall_cnt), 128'(SMAX));
        commit();
        flush = 1'b1;
        step();
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            dec_bus.in_valid    = ($urandom_range(0, 3) != 0);
            dec_bus.in_op       = 6'($urandom_range(0, 63));
            dec_bus.in_cls      = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            dec_bus.in_rs       = 5'($urandom_range(0, 7));
            dec_bus.in_rt       = 5'($urandom_range(0, 7));
            dec_bus.in_rd       = 5'($urandom_range(0, 7));
            dec_bus.in_imm16    = 16'($urandom);
            dec_bus.in_imm_zext = 1'($urandom_range(0, 1));
            label1    = ($urandom_range(0, 1) != 0) ? '0 : TW'($urandom_range(1, 7));
            label2    = ($urandom_range(0, 1) != 0) ? '0 : TW'($urandom_range(1, 7));
            data1     = $urandom;
            data2     = $urandom;
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag   = TW'($urandom_range(0, 7));
            cdb_data  = $urandom;
            free_valid = NC'($urandom_range(0, 7));
            free_tag   = (NC*TW)'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end

        idle();
        flush = 1'b1;
        step();
        idle();
        step();
        check("sb_drain", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_stage_n.md
Name: issue_stage_n

Overview:
- Parametrised successor of the operand-outflow stage in the Tomasulo core; sits between the decoder and NUM_CLS reservation-station classes.
- Accepts one decoded instruction per cycle through a valid/ready handshake and reads source tags/values from the register file and register-status table.
- Holds the instruction in a one-entry stage register, snooping the CDB for missing operands, until its reservation-station class offers a free tag.
- On issue, dispatches to that class and renames rd by writing the allocated tag.

Parameters:
- DATA_W, 32, operand/CDB data width
- TAG_W, 5, label width; tag value 0 means "value ready"
- NUM_CLS, 2, number of reservation-station classes
- CLS_W, 1, width of class index (clog2 of NUM_CLS, minimum 1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of the held instruction
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept this cycle
- in_op  in  6  opcode
- in_cls  in  CLS_W  target reservation-station class
- in_rs  in  5  source register j
- in_rt  in  5  source register k
- in_rd  in  5  destination register
- in_imm16  in  16  immediate
- in_imm_zext  in  1  1 = zero-extend, 0 = sign-extend
- readAddr1  out  5  = in_rs (combinational)
- readAddr2  out  5  = in_rt (combinational)
- labelIn1, labelIn2  in  TAG_W  status tags from register-status table
- dataIn1, dataIn2  in  DATA_W  register-file values
- cdb_valid  in  1  CDB broadcast
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- free_valid  in  NUM_CLS  class c has a free entry
- free_tag  in  NUM_CLS*TAG_W  tag of the free entry, per class
- iss_valid  out  NUM_CLS  one-hot dispatch strobe
- iss_op  out  6  opcode
- iss_tag1, iss_tag2  out  TAG_W  operand tags (0 = value valid)
- iss_val1, iss_val2  out  DATA_W  operand values
- iss_imm  out  32  extended immediate
- iss_dest  out  TAG_W  allocated destination tag
- rat_we  out  1  rename write enable
- rat_addr  out  5  register renamed
- rat_tag  out  TAG_W  new status tag
- stall_cnt  out  CNT_W  saturating count of cycles held-valid but not issued

Behaviour:
- State: a held-valid bit V plus the held fields. Reset clears V, all held fields and stall_cnt to 0.
  - Every output derived from them is 0 while V=0, except readAddr1/readAddr2, which follow the inputs.
- fire = V & free_valid[cls] & ~flush.
- in_ready = ~V | fire. Accept when in_valid & in_ready; the accepted instruction is held (V=1) from the next cycle.
- Minimum latency is 1 cycle: accept in cycle t, issue in t+1 if a tag is free. Back-to-back accept and issue gives 1 instruction/cycle.
- Operand capture at accept, per source, in priority order:
  1. If fire, the held rd!=0 and the held rd == new source register: tag = held dest tag, value = 0 (same-cycle rename forwarding).
  2. Else if labelIn!=0, cdb_valid and cdb_tag==labelIn: tag = 0, value = cdb_data.
  3. Else tag = labelIn, value = dataIn.
- While V=1: each held operand with tag!=0 that matches a valid CDB broadcast takes cdb_data, and its tag becomes 0.
- Issue outputs are combinational from the held state, with the current-cycle CDB match applied, so a broadcast in the issue cycle is never lost.
- On fire:
  - iss_valid = one-hot of cls; iss_dest = free_tag[cls].
  - rat_we = (rd!=0), rat_addr = rd, rat_tag = free_tag[cls].
  - V clears unless a new instruction is accepted in the same cycle.
- Writes to $0 still consume a tag but never rename.
- iss_imm = {16{~in_imm_zext & imm[15]}, imm16}, computed at accept.
- flush: V=0 next cycle, in_ready=0 in the flush cycle, no issue, no rename; stall_cnt unchanged.
- stall_cnt increments when V & ~fire & ~flush; it saturates at all-ones and is not wrapped.
- in_cls >= NUM_CLS is illegal; the design must never issue it, and assertion coverage is required.
- Asynchronous reset mid-hold discards the instruction with no issue.

Decomposition:
- Shared package:
  - TAG_NONE = 0
  - class codes CLS_ALU = 0, CLS_MEM = 1
  - opcode constants shared with the decoder
- One natural sub-module, operand_capture: instantiated twice; implements the accept-time priority mux plus CDB snoop and tag clear for one source.

Test Plan:
- Reset asserted mid-hold (V=1, free_valid=0) -> iss_valid=0, in_ready=1, stall_cnt=0 next cycle.
- Accept add with labelIn1=0, dataIn1=7, free_valid[0]=1, free_tag=3 -> next cycle iss_valid=01, iss_val1=7, iss_dest=3, rat_we=1, rat_tag=3.
- Held operand tag=4 with free_valid=0 for 3 cycles, CDB (4, 0x55) in cycle 2 -> iss_tag1=0, iss_val1=0x55 on issue; stall_cnt=3.
- Back-to-back I1 rd=r5 (tag 6) then I2 rs=r5 with stale labelIn1=0 -> I2 captures iss_tag1=6.
- Accept with labelIn2=9 while cdb (9, 0xAA) same cycle -> iss_tag2=0, iss_val2=0xAA; imm16=0x8000 with zext=0 -> iss_imm=0xFFFF8000.
- flush while V=1 and free_valid=1 -> no iss_valid, rat_we=0, V=0 next cycle; rd=0 issue -> rat_we=0.
